// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 widths, reset PC, opcodes and fetch-mode encoding.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // RUN keeps responses; FLUSH discards responses requested before a redirect.
    typedef enum logic [0:0] {
        MODE_RUN   = 1'b0,
        MODE_FLUSH = 1'b1
    } fetch_mode_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with flush and occupancy count; reads zero when empty.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32 instruction fetch: PC, credit-limited imem requests, redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter int          XLEN     = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    import riscv_pkg::*;

    localparam int                c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int                c_fifo_w = 2 * XLEN;
    localparam logic [c_cnt_w:0]  c_depth  = (c_cnt_w + 1)'(DEPTH);
    localparam logic [XLEN-1:0]   c_rst_pc = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0]   c_step   = XLEN'(4);

    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     r_rsp_pc;
    logic [c_cnt_w-1:0]  r_inflight;
    logic [c_cnt_w-1:0]  r_drop;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_cnt_w:0]    w_credit_used;
    logic [XLEN-1:0]     w_target;
    logic [c_fifo_w-1:0] w_fifo_dout;
    logic                w_fifo_empty;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_kept;
    logic                w_pop;
    fetch_mode_e         w_mode;

    assign w_target      = {redirect_pc[XLEN-1:2], 2'b00};
    // Every issued request holds a FIFO slot until consumed, so responses never overflow.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_req_valid   = !reset && !redirect_valid && (w_credit_used < c_depth);
    assign w_req_fire    = w_req_valid && imem_req_ready;

    always_comb begin
        w_mode = MODE_RUN;
        if (r_drop != '0) begin
            w_mode = MODE_FLUSH;
        end
    end

    assign w_kept = imem_rsp_valid && !redirect_valid && (w_mode == MODE_RUN);
    assign w_pop  = id_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= c_rst_pc;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_target;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + c_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_pc <= c_rst_pc;
        end else if (redirect_valid) begin
            r_rsp_pc <= w_target;
        end else if (w_kept) begin
            r_rsp_pc <= r_rsp_pc + c_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A response in the redirect cycle is already discarded, so it is not counted again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= '0;
        end else if (redirect_valid) begin
            r_drop <= r_inflight - {{(c_cnt_w-1){1'b0}}, imem_rsp_valid};
        end else if (imem_rsp_valid && (w_mode == MODE_FLUSH)) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_kept),
        .i_data  ({r_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign id_valid       = !w_fifo_empty;
    assign id_pc          = w_fifo_dout[c_fifo_w-1:XLEN];
    assign id_instr       = w_fifo_dout[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Randomized bench for fetch_stage against a queue-level fetch model.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    // Outstanding memory request; stale ones were overtaken by a redirect.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] exp_req_addr;
    logic [31:0] exp_pop_pc;
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        mem_q.delete();
        buf_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
            if (i > 0) begin
                check_eq("rst_id_valid", 32'(id_valid), 32'd0);
                check_eq("rst_id_pc", id_pc, 32'd0);
                check_eq("rst_id_instr", id_instr, 32'd0);
                check_eq("rst_req_addr", imem_req_addr, RST_PC);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        reset        = 1'b0;
        exp_req_addr = RST_PC;
        exp_pop_pc   = RST_PC;
    endtask

    // One clock of stimulus, checking and model update.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input bit idr);
        bit          rsp;
        bit          exp_valid;
        req_t        r;
        logic [31:0] t_al;

        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        id_ready       = idr;
        rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;

        @(negedge clk);
        exp_valid = !redir && ((mem_q.size() + buf_q.size()) < DEPTH);
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_valid));
        if (imem_req_valid) begin
            check_eq("req_addr", imem_req_addr, exp_req_addr);
        end
        check_eq("id_valid", 32'(id_valid), 32'(buf_q.size() > 0));
        if (buf_q.size() > 0) begin
            check_eq("id_pc", id_pc, buf_q[0]);
            check_eq("id_instr", id_instr, mem_word(buf_q[0]));
            if (idr && !redir) begin
                check_eq("seq_pc", id_pc, exp_pop_pc);
                exp_pop_pc = exp_pop_pc + 32'd4;
                void'(buf_q.pop_front());
            end
        end
        if (rsp) begin
            r = mem_q.pop_front();
            if (!redir && !r.stale) begin
                buf_q.push_back(r.addr);
            end
        end
        if (imem_req_valid && rdy) begin
            mem_q.push_back('{imem_req_addr, cyc + lat, 1'b0});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (redir) begin
            t_al = {tgt[31:2], 2'b00};
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            buf_q.delete();
            exp_req_addr = t_al;
            exp_pop_pc   = t_al;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        do_reset(3);

        // Streaming with an always-ready single-cycle memory
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Decode stall fills the credit window; release must lose nothing
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect with two-cycle memory and requests in flight
        lat = 2;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Misaligned target is word-aligned
        step(1'b1, 1'b1, 32'h0000_0203, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect coinciding with a response and a decode pop
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0500, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Reset in the middle of a stream with the buffer full
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Random traffic across several memory latencies
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            do_reset(2);
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom & 32'h0000_0FFF,
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RV32 core: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, accepts in-order responses, and buffers fetched instructions with their PCs for the decode/control stage that consumes opcode, funct3 and funct7. Branch and jump redirects from execute flush buffered and in-flight instructions and restart fetch at the target.

## Interface
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, maximum in-flight requests plus buffered instructions (power of 2, ≥2)

- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address, bits [1:0] always 0
- imem_rsp_valid  in  1  response valid, in request order, no backpressure
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  control transfer taken (branch/jal/jalr)
- redirect_pc  in  XLEN  target; bits [1:0] ignored, forced to 0
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode consumes
- id_instr  out  XLEN  instruction word
- id_pc  out  XLEN  PC of id_instr

## Operation
- fetch_pc register: reset RESET_PC; +4 on request handshake; loads {redirect_pc[XLEN-1:2],2'b00} on redirect (redirect wins over handshake).
- Credit rule: imem_req_valid = !reset && !redirect_valid && (inflight + fifo_count < DEPTH). Guarantees every response has a FIFO slot; FIFO never overflows.
- inflight counter (0..DEPTH): +1 on request handshake, −1 on response, both same cycle → unchanged.
- drop counter: on redirect loads inflight − (imem_rsp_valid ? 1 : 0); while nonzero each response is discarded and drop decrements. Two modes: RUN (drop==0, responses pushed) and FLUSH (drop>0, responses discarded); FLUSH→RUN when drop reaches 0. Requests may issue during FLUSH; their responses arrive after dropped ones and are kept.
- rsp_pc register: reset RESET_PC; loads redirect target on redirect; +4 per kept response. Kept response pushes {rsp_pc, imem_rsp_data} into FIFO.
- Output FIFO, DEPTH entries: id_valid = !empty; head drives id_instr/id_pc; pop on id_valid && id_ready. Push and pop in same cycle allowed at any occupancy.
- Redirect: FIFO cleared same edge; a response arriving in the redirect cycle is discarded; id_ready in that cycle is ignored (nothing popped counts as consumed).
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, id_valid 0, id_instr 0, id_pc 0 in empty FIFO; inflight, drop, fifo_count 0. Memory must be reset in the same cycle; no pre-reset responses are tolerated.

## Timing
- First cycle with reset low: imem_req_valid=1, addr RESET_PC.
- Fetch-to-decode latency: memory latency L plus 1 cycle (response registered into FIFO; id_valid the cycle after imem_rsp_valid).
- Back-to-back throughput 1 instr/cycle requires DEPTH ≥ L+1.
- Redirect at cycle T: id_valid=0 at T+1; request for target issued at T+1 if ready; target instruction at decode at T+1+L+1 earliest.
- imem_req_valid, once high, may drop only on redirect or reset.

## Structure
- Shared package riscv_pkg: XLEN, RESET_PC default, ILEN, opcode constants (OP_R 7'b0110011, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI) shared with the control unit.
- One sub-module: fetch_fifo (parameterised width/depth synchronous FIFO with flush, count output). Counters and PC logic stay in fetch_stage.

## Test plan
- Reset release, L=1 memory always ready, id_ready=1 → requests 0x0,0x4,0x8… one per cycle; id_pc 0x0 appears 2 cycles after first request, then one per cycle.
- id_ready=0 for 10 cycles, DEPTH=2 → exactly 2 requests outstanding/buffered, imem_req_valid=0 until pop; no instruction lost or duplicated on release.
- Redirect to 0x100 with 2 in flight, L=2 → both old responses dropped, next id_pc 0x100 then 0x104; no 0x8/0xC ever at decode.
- Redirect coinciding with imem_rsp_valid and id_valid&&id_ready → that response discarded, drop = inflight−1, FIFO empty next cycle.
- redirect_pc 0x203 → imem_req_addr 0x200, id_pc 0x200.
- Reset asserted mid-stream with 2 buffered → next cycle id_valid=0, imem_req_valid=0; after release fetch restarts at RESET_PC.
